io_bus_bridge: RTL and testbench
================================

# io_bus_bridge

Parametrised IO-space bridge between the CPU Wishbone bus and N peripheral slaves (IOC, FDC, latches, podules and future devices). It replaces the fixed combinational read-data priority mux with a registered, sequenced access. Per-access features: IOC speed-class wait states timed from the 2 MHz/8 MHz enables, per-slave data width steering, slave ready extension, bus timeout with error, and cycle abort.

## Interface
Parameters:
- NSLAVE, 4, number of slave channels (1..8); channel 0 has highest decode priority.
- TIMEOUT, 255, cycles of clkcpu after entering WAIT before error (8-bit counter, 1..255).
- DEFAULT_DAT, 32'hFFFF_FFFF, read data returned for unclaimed addresses.

Ports (one clock; reset is synchronous and active-high):
- clkcpu  in  1  CPU clock, all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- clk2m_en  in  1  2 MHz clock enable, one clkcpu cycle wide.
- clk8m_en  in  1  8 MHz clock enable, one clkcpu cycle wide.
- wb_cyc, wb_stb, wb_we  in  1  CPU Wishbone controls.
- wb_adr  in  24  CPU byte address [25:2]; [20:19] is the speed class.
- wb_dat_i  in  32  CPU write data.
- wb_dat_o  out  32  registered read data.
- wb_ack  out  1  one-cycle completion.
- wb_err  out  1  one-cycle timeout error.
- sl_hit  in  NSLAVE  per-slave address decode from MEMC.
- sl_width  in  2*NSLAVE  per slave: 0 = 8-bit on [23:16], 1 = 16-bit on [15:0], 2 = 32-bit, 3 = 8-bit on [7:0].
- s_cyc, s_stb  out  NSLAVE  one-hot strobes to the selected slave.
- s_we  out  1  registered write enable.
- s_adr  out  14  registered address [15:2].
- s_dat_o  out  16  write data steered to the slave width; 8-bit widths drive the byte in [7:0].
- s_dat_i  in  32*NSLAVE  slave read data, slave k at [32k+31:32k].
- s_rdy  in  NSLAVE  slave ready; tie high for fixed-timing slaves.

## Operation
- States: IDLE, WAIT, DONE, ERR.
- IDLE: on wb_cyc & wb_stb, latch the lowest-index asserted sl_hit as channel. Also latch wb_we, wb_adr[15:2], steered write data, and speed = wb_adr[20:19]. Go to WAIT.
- No hit: go directly to DONE with wb_dat_o = DEFAULT_DAT; no slave strobe.
- WAIT: s_cyc/s_stb asserted for the channel. The wait counter loads from speed:
  - 0 (slow): 4 clk2m_en pulses.
  - 1 (medium): 3 clk2m_en pulses.
  - 2 (fast): 2 clk2m_en pulses.
  - 3 (sync): 2 clk8m_en pulses.
- WAIT exit: when count == 0 and s_rdy[channel] is high, capture read data into wb_dat_o and go to DONE.
- Read data capture, zero-extended:
  - width 0: s_dat_i[23:16] to [7:0].
  - width 1: [15:0].
  - width 2: [31:0].
  - width 3: [7:0].
- Timeout counter: runs every clkcpu in WAIT. On reaching TIMEOUT, go to ERR; wb_dat_o = DEFAULT_DAT.
- DONE: wb_ack = 1 for one cycle, strobes low, then IDLE.
- ERR: wb_err = 1 for one cycle, strobes low, then IDLE.
- Abort: wb_cyc low in WAIT → IDLE next cycle, strobes drop, no ack/err, wb_dat_o unchanged.
- Enable pulse arriving in the same cycle the counter loads is not counted.
- Writes: wb_dat_o is not updated.

## Timing
- Reset values:
  - State IDLE.
  - wb_ack, wb_err, s_cyc, s_stb, s_we = 0.
  - s_adr, s_dat_o = 0.
  - wb_dat_o = DEFAULT_DAT.
  - Counters 0.
- Unclaimed access: strobe seen at edge N → wb_ack high in cycle N+1.
- Claimed access: ack in cycle after the last required enable pulse with s_rdy high. Minimum = 2 clk8m_en periods + 1 cycle.
- Back-to-back: after wb_ack, a new access can be latched in the cycle following DONE (one idle cycle between accesses).
- Reset mid-access: returns to IDLE on that edge; no ack/err is emitted.
- wb_ack and wb_err are never high together.

## Structure
- Package io_bus_pkg holds:
  - state enum (IDLE, WAIT, DONE, ERR)
  - speed codes SPD_SLOW/MED/FAST/SYNC
  - width codes W8_HI, W16, W32, W8_LO
  - wait-count constants per speed
- Sub-module io_wait_timer: loads from speed, decrements on the chosen enable, flags zero.
- Top (io_bus_bridge) contains the FSM, priority encoder, steering and timeout counter.

## Test plan
- Read with no sl_hit → wb_ack at cycle N+1, wb_dat_o = 32'hFFFF_FFFF.
- Read channel 1 (width 0, speed 2, s_dat_i = 32'h00A5_0000) → ack after 2 clk2m_en pulses, wb_dat_o = 32'h0000_00A5.
- Write channel 0 (width 1, wb_dat_i = 32'h1234_5678) → s_dat_o = 16'h5678, s_we = 1, single ack.
- sl_hit = 4'b0110 → only s_stb[1] asserted; s_dat_i of channel 2 is ignored.
- s_rdy held low, TIMEOUT = 16 → wb_err one cycle at 16 cycles after WAIT entry, no ack, state IDLE.
- wb_cyc dropped mid-WAIT, then rst_i mid-WAIT on a second access → strobes low next cycle, no ack/err, all outputs at reset values.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO-space bridge: FSM states, speed and
// width codes, wait counts per speed class and data steering helpers.
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [1:0] SPD_SLOW = 2'd0;
  localparam logic [1:0] SPD_MED  = 2'd1;
  localparam logic [1:0] SPD_FAST = 2'd2;
  localparam logic [1:0] SPD_SYNC = 2'd3;

  localparam logic [1:0] W8_HI = 2'd0;
  localparam logic [1:0] W16   = 2'd1;
  localparam logic [1:0] W32   = 2'd2;
  localparam logic [1:0] W8_LO = 2'd3;

  localparam logic [2:0] WAIT_SLOW = 3'd4;
  localparam logic [2:0] WAIT_MED  = 3'd3;
  localparam logic [2:0] WAIT_FAST = 3'd2;
  localparam logic [2:0] WAIT_SYNC = 3'd2;

  function automatic logic [2:0] wait_count(input logic [1:0] spd);
    logic [2:0] n;
    case (spd)
      SPD_SLOW: n = WAIT_SLOW;
      SPD_MED:  n = WAIT_MED;
      SPD_FAST: n = WAIT_FAST;
      default:  n = WAIT_SYNC;
    endcase
    return n;
  endfunction

  // Byte-wide slaves always see their byte on the low lane.
  function automatic logic [15:0] steer_wr(input logic [1:0] w, input logic [31:0] d);
    logic [15:0] r;
    case (w)
      W8_HI:   r = {8'h00, d[23:16]};
      W8_LO:   r = {8'h00, d[7:0]};
      default: r = d[15:0];
    endcase
    return r;
  endfunction

  function automatic logic [31:0] steer_rd(input logic [1:0] w, input logic [31:0] d);
    logic [31:0] r;
    case (w)
      W8_HI:   r = {24'h000000, d[23:16]};
      W16:     r = {16'h0000, d[15:0]};
      W32:     r = d;
      default: r = {24'h000000, d[7:0]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/io_wait_timer.sv
// Speed-class wait timer: loads a pulse count on access start and counts it
// down on the clock enable that belongs to the latched speed class.
module io_wait_timer
  import io_bus_pkg::*;
(
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       load_i,
  input  logic       run_i,
  input  logic [1:0] speed_i,
  input  logic       clk2m_en_i,
  input  logic       clk8m_en_i,
  output logic       expire_o
);

  logic [2:0] cnt_q, cnt_d;
  logic       sync_q, sync_d;
  logic       tick;

  assign tick = run_i & (sync_q ? clk8m_en_i : clk2m_en_i);

  // A pulse coinciding with the load is dropped because load wins.
  always_comb begin
    cnt_d  = cnt_q;
    sync_d = sync_q;
    if (load_i) begin
      cnt_d  = wait_count(speed_i);
      sync_d = (speed_i == SPD_SYNC);
    end else if (tick && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q  <= 3'd0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  // Expire in the cycle of the last pulse so completion follows it directly.
  assign expire_o = (cnt_q == 3'd0) | ((cnt_q == 3'd1) & tick);

endmodule

// File: rtl/io_bus_bridge.sv
// Registered Wishbone-to-IO bridge: priority decode of slave hits, speed-class
// wait states, width steering, slave ready extension, timeout and abort.
module io_bus_bridge
  import io_bus_pkg::*;
#(
  parameter int          NSLAVE      = 4,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] DEFAULT_DAT = 32'hFFFF_FFFF
) (
  input  logic                   clkcpu,
  input  logic                   rst_i,
  input  logic                   clk2m_en,
  input  logic                   clk8m_en,
  input  logic                   wb_cyc,
  input  logic                   wb_stb,
  input  logic                   wb_we,
  input  logic [23:0]            wb_adr,
  input  logic [31:0]            wb_dat_i,
  output logic [31:0]            wb_dat_o,
  output logic                   wb_ack,
  output logic                   wb_err,
  input  logic [NSLAVE-1:0]      sl_hit,
  input  logic [2*NSLAVE-1:0]    sl_width,
  output logic [NSLAVE-1:0]      s_cyc,
  output logic [NSLAVE-1:0]      s_stb,
  output logic                   s_we,
  output logic [13:0]            s_adr,
  output logic [15:0]            s_dat_o,
  input  logic [32*NSLAVE-1:0]   s_dat_i,
  input  logic [NSLAVE-1:0]      s_rdy
);

  localparam int         CH_W    = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e            state_q;
  logic [CH_W-1:0]   ch_q;
  logic [1:0]        width_q;
  logic [7:0]        to_cnt_q;
  logic [NSLAVE-1:0] sel_q;
  logic              ack_q, err_q, we_q;
  logic [13:0]       adr_q;
  logic [15:0]       wdat_q;
  logic [31:0]       rdat_q;

  logic              hit_any;
  logic [CH_W-1:0]   hit_idx;
  logic [NSLAVE-1:0] hit_oh;
  logic [1:0]        hit_width;
  logic [31:0]       rd_sel;
  logic              rdy_sel;
  logic              start, load, run, expire;
  logic              unused_bits;

  // Lowest index wins, so scan downwards and let later matches overwrite.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if (sl_hit[i]) begin
        hit_any = 1'b1;
        hit_idx = CH_W'(i);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NSLAVE; gi++) begin : g_onehot
      assign hit_oh[gi] = hit_any && (hit_idx == CH_W'(gi));
    end
  endgenerate

  assign hit_width = sl_width[2*hit_idx +: 2];
  assign rd_sel    = s_dat_i[32*ch_q +: 32];
  assign rdy_sel   = s_rdy[ch_q];

  assign start = (state_q == IDLE) && wb_cyc && wb_stb;
  assign load  = start && hit_any;
  assign run   = (state_q == WAIT);

  io_wait_timer u_timer (
    .clk_i      (clkcpu),
    .srst_i     (rst_i),
    .load_i     (load),
    .run_i      (run),
    .speed_i    (wb_adr[20:19]),
    .clk2m_en_i (clk2m_en),
    .clk8m_en_i (clk8m_en),
    .expire_o   (expire)
  );

  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      width_q  <= 2'd0;
      to_cnt_q <= 8'd0;
      sel_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= 14'd0;
      wdat_q   <= 16'd0;
      rdat_q   <= DEFAULT_DAT;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            we_q     <= wb_we;
            adr_q    <= wb_adr[15:2];
            wdat_q   <= steer_wr(hit_width, wb_dat_i);
            ch_q     <= hit_idx;
            width_q  <= hit_width;
            to_cnt_q <= 8'd0;
            if (hit_any) begin
              sel_q   <= hit_oh;
              state_q <= WAIT;
            end else begin
              ack_q   <= 1'b1;
              state_q <= DONE;
              if (!wb_we) rdat_q <= DEFAULT_DAT;
            end
          end
        end
        WAIT: begin
          // Abort beats completion and timeout; completion beats timeout.
          if (!wb_cyc) begin
            sel_q   <= '0;
            state_q <= IDLE;
          end else if (expire && rdy_sel) begin
            sel_q   <= '0;
            ack_q   <= 1'b1;
            state_q <= DONE;
            if (!we_q) rdat_q <= steer_rd(width_q, rd_sel);
          end else if (to_cnt_q == TO_LAST) begin
            sel_q   <= '0;
            err_q   <= 1'b1;
            state_q <= ERR;
            if (!we_q) rdat_q <= DEFAULT_DAT;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_dat_o = rdat_q;
  assign wb_ack   = ack_q;
  assign wb_err   = err_q;
  assign s_cyc    = sel_q;
  assign s_stb    = sel_q;
  assign s_we     = we_q;
  assign s_adr    = adr_q;
  assign s_dat_o  = wdat_q;

  assign unused_bits = ^{wb_adr[23:21], wb_adr[18:16], wb_adr[1:0], wb_dat_i[31:24]};

endmodule

// File: tb/tb_io_bus_bridge.sv
// Bench for io_bus_bridge: fixed vectors, abort/reset sequences and random
// accesses checked against a pulse-counting reference model.
module tb_io_bus_bridge;

  localparam int          NS  = 4;
  localparam int          TO  = 16;
  localparam logic [31:0] DEF = 32'hFFFF_FFFF;

  logic            clkcpu = 1'b0;
  logic            rst_i = 1'b1;
  logic            clk2m_en = 1'b0, clk8m_en = 1'b0;
  logic            wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [23:0]     wb_adr = '0;
  logic [31:0]     wb_dat_i = '0;
  logic [31:0]     wb_dat_o;
  logic            wb_ack, wb_err;
  logic [NS-1:0]   sl_hit = '0;
  logic [2*NS-1:0] sl_width = '0;
  logic [NS-1:0]   s_cyc, s_stb;
  logic            s_we;
  logic [13:0]     s_adr;
  logic [15:0]     s_dat_o;
  logic [32*NS-1:0] s_dat_i = '0;
  logic [NS-1:0]   s_rdy = '0;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_dat = DEF;

  always #5 clkcpu = ~clkcpu;

  io_bus_bridge #(.NSLAVE(NS), .TIMEOUT(TO), .DEFAULT_DAT(DEF)) dut (
    .clkcpu(clkcpu), .rst_i(rst_i), .clk2m_en(clk2m_en), .clk8m_en(clk8m_en),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .wb_err(wb_err),
    .sl_hit(sl_hit), .sl_width(sl_width), .s_cyc(s_cyc), .s_stb(s_stb),
    .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_rdy(s_rdy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // outcome: 0 ack, 1 err, 2 aborted by wb_cyc, 3 reset. kill picks 1/2 at pending cycle kill_at.
  task automatic access(input string nm, input logic [3:0] hit, input logic [7:0] widths,
                        input logic we, input logic [23:0] adr, input logic [31:0] wdat,
                        input logic [127:0] sdat, input int rdy_pct, input bit rnd_en,
                        input int kill, input int kill_at, output int outcome);
    int          ch, need, pulses, c;
    logic [1:0]  w;
    logic [3:0]  oh;
    logic [15:0] exp_sdat;
    logic [31:0] raw, rd;
    bit          en2, en8, rdy;
    ch = -1;
    for (int i = 0; i < NS; i++) if (hit[i] && ch < 0) ch = i;
    w  = (ch >= 0) ? widths[2*ch +: 2] : 2'd0;
    oh = (ch >= 0) ? (4'b0001 << ch) : 4'b0000;
    case (adr[20:19])
      2'd0: need = 4;
      2'd1: need = 3;
      default: need = 2;
    endcase
    case (w)
      2'd0: exp_sdat = {8'h00, wdat[23:16]};
      2'd3: exp_sdat = {8'h00, wdat[7:0]};
      default: exp_sdat = wdat[15:0];
    endcase
    raw = (ch >= 0) ? sdat[32*ch +: 32] : 32'h0;
    case (w)
      2'd0: rd = {24'h0, raw[23:16]};
      2'd1: rd = {16'h0, raw[15:0]};
      2'd2: rd = raw;
      default: rd = {24'h0, raw[7:0]};
    endcase

    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = wdat;
    sl_hit = hit; sl_width = widths; s_dat_i = sdat;
    clk2m_en = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    clk8m_en = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    s_rdy = 4'($urandom);
    pulses = 0; c = 0;
    outcome = (ch < 0) ? 0 : -1;

    while (outcome < 0) begin
      @(negedge clkcpu);
      c++;
      chk($sformatf("%s wait ctl c%0d", nm, c), {22'h0, wb_ack, wb_err, s_cyc, s_stb}, {22'h0, 2'b00, oh, oh});
      if (c == 1) begin
        chk($sformatf("%s we/adr", nm), {17'h0, s_we, s_adr}, {17'h0, we, adr[15:2]});
        chk($sformatf("%s s_dat_o", nm), {16'h0, s_dat_o}, {16'h0, exp_sdat});
      end
      en2 = rnd_en ? ($urandom_range(0, 2) == 0) : (c % 2 == 0);
      en8 = rnd_en ? ($urandom_range(0, 1) == 1) : (c % 2 == 1);
      rdy = ($urandom_range(0, 99) < rdy_pct);
      clk2m_en = en2; clk8m_en = en8;
      s_rdy = 4'($urandom);
      s_rdy[ch] = rdy;
      if (kill != 0 && c == kill_at) begin
        if (kill == 1) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
        else rst_i = 1'b1;
        outcome = 1 + kill;
      end else begin
        pulses += (adr[20:19] == 2'd3) ? int'(en8) : int'(en2);
        if (pulses >= need && rdy) outcome = 0;
        else if (c == TO) outcome = 1;
      end
    end

    @(negedge clkcpu);
    clk2m_en = 1'b0; clk8m_en = 1'b0;
    case (outcome)
      0: begin
        if (!we) exp_dat = (ch < 0) ? DEF : rd;
        chk($sformatf("%s ack ctl", nm), {22'h0, wb_ack, wb_err, s_cyc, s_stb}, {22'h0, 2'b10, 8'h00});
      end
      1: begin
        if (!we) exp_dat = DEF;
        chk($sformatf("%s err ctl", nm), {22'h0, wb_ack, wb_err, s_cyc, s_stb}, {22'h0, 2'b01, 8'h00});
      end
      2: chk($sformatf("%s abort ctl", nm), {22'h0, wb_ack, wb_err, s_cyc, s_stb}, 32'h0);
      default: begin
        exp_dat = DEF;
        chk($sformatf("%s reset ctl", nm), {22'h0, wb_ack, wb_err, s_cyc, s_stb}, 32'h0);
        chk($sformatf("%s reset regs", nm), {1'b0, s_we, s_adr, s_dat_o}, 32'h0);
      end
    endcase
    if (outcome < 2)
      chk($sformatf("%s latched we/adr", nm), {17'h0, s_we, s_adr}, {17'h0, we, adr[15:2]});
    chk($sformatf("%s dat", nm), wb_dat_o, exp_dat);
    wb_cyc = 1'b0; wb_stb = 1'b0; rst_i = 1'b0;
    if (outcome < 2) begin
      @(negedge clkcpu);
      chk($sformatf("%s idle ctl", nm), {22'h0, wb_ack, wb_err, s_cyc, s_stb}, 32'h0);
    end
  endtask

  typedef struct {
    logic [3:0]   hit;
    logic [7:0]   widths;
    logic         we;
    logic [23:0]  adr;
    logic [31:0]  wdat;
    logic [127:0] sdat;
    int           rdy_pct;
    int           exp_outcome;
    logic [31:0]  exp_dat;
    logic [15:0]  exp_sdat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int oc;
    vecs[0] = '{4'b0000, 8'h00, 1'b0, 24'h00_0010, 32'h0, 128'h0, 100, 0, 32'hFFFF_FFFF, 16'h0};
    vecs[1] = '{4'b0010, 8'b11_10_00_01, 1'b0, 24'h10_0004, 32'h0,
                {32'h0, 32'h0, 32'h00A5_0000, 32'h0}, 100, 0, 32'h0000_00A5, 16'h0};
    vecs[2] = '{4'b0001, 8'b11_10_00_01, 1'b1, 24'h10_0008, 32'h1234_5678, 128'h0, 100, 0, 32'h0000_00A5, 16'h5678};
    vecs[3] = '{4'b0110, 8'b11_01_10_00, 1'b0, 24'h10_000C, 32'h0,
                {32'h0, 32'h5555_5555, 32'hDEAD_BEEF, 32'h0}, 100, 0, 32'hDEAD_BEEF, 16'h0};
    vecs[4] = '{4'b1000, 8'b11_00_00_00, 1'b0, 24'h18_0020, 32'h0,
                {32'h1122_3344, 96'h0}, 100, 0, 32'h0000_0044, 16'h0};
    vecs[5] = '{4'b0100, 8'b00_01_00_00, 1'b0, 24'h00_0040, 32'h0,
                {32'h0, 32'hCAFE_F00D, 64'h0}, 100, 0, 32'h0000_F00D, 16'h0};
    vecs[6] = '{4'b0010, 8'b00_00_00_00, 1'b1, 24'h08_0044, 32'h00AB_0000, 128'h0, 100, 0, 32'h0000_F00D, 16'h00AB};
    vecs[7] = '{4'b0001, 8'b00_00_00_10, 1'b0, 24'h10_0050, 32'h0, 128'h0, 0, 1, 32'hFFFF_FFFF, 16'h0};
    vecs[8] = '{4'b0000, 8'h00, 1'b1, 24'h00_0060, 32'h0, 128'h0, 100, 0, 32'hFFFF_FFFF, 16'h0};
    vecs[9] = '{4'b0001, 8'b00_00_00_11, 1'b0, 24'h10_0064, 32'h0,
                {96'h0, 32'hAABB_CCDD}, 100, 0, 32'h0000_00DD, 16'h0};

    rst_i = 1'b1;
    repeat (2) @(negedge clkcpu);
    chk("reset ctl", {22'h0, wb_ack, wb_err, s_cyc, s_stb}, 32'h0);
    chk("reset regs", {1'b0, s_we, s_adr, s_dat_o}, 32'h0);
    chk("reset dat", wb_dat_o, DEF);
    rst_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      access($sformatf("vec%0d", i), vecs[i].hit, vecs[i].widths, vecs[i].we, vecs[i].adr,
             vecs[i].wdat, vecs[i].sdat, vecs[i].rdy_pct, 1'b0, 0, 0, oc);
      chk($sformatf("vec%0d outcome", i), 32'(oc), 32'(vecs[i].exp_outcome));
      chk($sformatf("vec%0d table dat", i), wb_dat_o, vecs[i].exp_dat);
      if (vecs[i].hit != 4'b0000)
        chk($sformatf("vec%0d table sdat", i), {16'h0, s_dat_o}, {16'h0, vecs[i].exp_sdat});
      $display("vec%0d outcome=%0d dat=%h", i, oc, wb_dat_o);
    end

    access("abort", 4'b0010, 8'h00, 1'b0, 24'h00_0070, 32'h0, {96'h0, 32'h1}, 0, 1'b0, 1, 3, oc);
    chk("abort outcome", 32'(oc), 32'd2);
    chk("abort dat kept", wb_dat_o, 32'h0000_00DD);
    $display("abort outcome=%0d dat=%h", oc, wb_dat_o);

    access("rstmid", 4'b0001, 8'h02, 1'b1, 24'h00_3FFC, 32'h0000_BEEF, 128'h0, 0, 1'b0, 2, 4, oc);
    chk("rstmid outcome", 32'(oc), 32'd3);
    $display("rstmid outcome=%0d dat=%h", oc, wb_dat_o);

    for (int n = 0; n < 80; n++) begin
      logic [3:0]   hit;
      logic [127:0] sd;
      hit = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
      sd  = {$urandom, $urandom, $urandom, $urandom};
      access($sformatf("rnd%0d", n), hit, 8'($urandom), 1'($urandom), 24'($urandom), $urandom, sd,
             70, 1'b1, ($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(1, 6), oc);
      $display("rnd%0d hit=%b outcome=%0d dat=%h", n, hit, oc, wb_dat_o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
